// File: rtl/mycpu_pkg.sv
// Shared types and instruction field positions for the mycpu control unit.
// Optional feature macro used by this slice: MYCPU_ILLEGAL_TRAP_EN.
package mycpu_pkg;

  typedef enum logic [3:0] {
    FMOVA = 4'h0, FINC = 4'h1, FADD = 4'h2, FMOVB = 4'h3,
    FSUB  = 4'h5, FDEC = 4'h6, FSHR = 4'h7, FAND  = 4'h8,
    FSHL  = 4'h9, FOR  = 4'hA, FXOR = 4'hC, FNOT  = 4'hE
  } fs_t;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXEC    = 3'd2,
    ST_LOAD_WB = 3'd3,
    ST_HALT    = 3'd4
  } ctrl_state_t;

  typedef enum logic [1:0] {
    CL_ALU = 2'b00, CL_MEM = 2'b01, CL_BRANCH = 2'b10, CL_CTRL = 2'b11
  } instr_class_t;

  typedef enum logic [1:0] {
    BR_BRA = 2'b00, BR_BEQ = 2'b01, BR_BLT = 2'b10, BR_BNE = 2'b11
  } br_cond_t;

  localparam int CLASS_LSB = 14;
  localparam int FS_LSB    = 10;
  localparam int MB_BIT    = 9;
  localparam int DR_LSB    = 6;
  localparam int SA_LSB    = 3;
  localparam int SB_LSB    = 0;
  localparam int ST_BIT    = 13;
  localparam int MZ_LSB    = 9;
  localparam int COND_LSB  = 12;
  localparam int OFF_LSB   = 6;
  localparam int CTRL_LSB  = 12;

  function automatic logic [15:0] sext_off(input logic [5:0] off);
    return {{10{off[5]}}, off};
  endfunction

endpackage

// File: rtl/mycpu_ctrl_decode.sv
// Combinational decode of an instruction word into class, fields, legality
// and the control word presented to the datapath during EXEC.
module mycpu_ctrl_decode
  import mycpu_pkg::*;
(
  input  logic [15:0] ir_i,
  output logic [3:0]  fs_o,
  output logic [2:0]  da_o,
  output logic [2:0]  aa_o,
  output logic [2:0]  ba_o,
  output logic [2:0]  dr_o,
  output logic [15:0] const_o,
  output logic        mb_o,
  output logic        rw_o,
  output logic        mw_o,
  output logic        is_load_o,
  output logic        is_branch_o,
  output logic        is_halt_o,
  output logic        illegal_o,
  output logic [1:0]  cond_o,
  output logic [15:0] off_o
);

  instr_class_t cls_s;
  logic [2:0]   sa_s;
  logic [2:0]   sb_s;

  assign cls_s  = instr_class_t'(ir_i[CLASS_LSB +: 2]);
  assign dr_o   = ir_i[DR_LSB +: 3];
  assign sa_s   = ir_i[SA_LSB +: 3];
  assign sb_s   = ir_i[SB_LSB +: 3];
  assign cond_o = ir_i[COND_LSB +: 2];
  assign off_o  = sext_off(ir_i[OFF_LSB +: 6]);

  // Illegal encodings leave every strobe low so they can never disturb state.
  always_comb begin
    fs_o        = FMOVA;
    da_o        = 3'd0;
    aa_o        = 3'd0;
    ba_o        = 3'd0;
    const_o     = 16'h0000;
    mb_o        = 1'b0;
    rw_o        = 1'b0;
    mw_o        = 1'b0;
    is_load_o   = 1'b0;
    is_branch_o = 1'b0;
    is_halt_o   = 1'b0;
    illegal_o   = 1'b0;
    case (cls_s)
      CL_ALU: begin
        fs_o    = ir_i[FS_LSB +: 4];
        mb_o    = ir_i[MB_BIT];
        da_o    = dr_o;
        aa_o    = sa_s;
        ba_o    = sb_s;
        const_o = {13'd0, sb_s};
        rw_o    = 1'b1;
      end
      CL_MEM: begin
        if (ir_i[MZ_LSB +: 4] != 4'd0) begin
          illegal_o = 1'b1;
        end else if (ir_i[ST_BIT]) begin
          aa_o = sa_s;
          ba_o = sb_s;
          mw_o = 1'b1;
        end else begin
          aa_o      = sa_s;
          is_load_o = 1'b1;
        end
      end
      CL_BRANCH: begin
        fs_o        = FSUB;
        aa_o        = sa_s;
        ba_o        = sb_s;
        is_branch_o = 1'b1;
      end
      CL_CTRL: begin
        case (ir_i[CTRL_LSB +: 2])
          2'b00:   is_halt_o = 1'b0;
          2'b11:   is_halt_o = 1'b1;
          default: illegal_o = 1'b1;
        endcase
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mycpu_ctrl.sv
// Multi-cycle sequencer for mycpu: FETCH/DECODE/EXEC(/LOAD_WB), pc and ir.
// MYCPU_ILLEGAL_TRAP_EN turns illegal encodings into a halting trap with illegal_out.
module mycpu_ctrl
  import mycpu_pkg::*;
#(
  parameter logic [15:0] PC_RESET = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] imem_addr_out,
  input  logic [15:0] imem_data_in,
  input  logic        z_in,
  input  logic        n_in,
  output logic [3:0]  fs_out,
  output logic [2:0]  da_out,
  output logic [2:0]  aa_out,
  output logic [2:0]  ba_out,
  output logic [15:0] const_out,
  output logic        mb_out,
  output logic        md_out,
  output logic        rw_out,
  output logic        mw_out,
  output logic        halted_out
`ifdef MYCPU_ILLEGAL_TRAP_EN
  , output logic      illegal_out
`endif
);

  ctrl_state_t state_q;
  logic [15:0] pc_q, ir_q, const_q;
  logic [3:0]  fs_q;
  logic [2:0]  da_q, aa_q, ba_q;
  logic        mb_q, md_q, rw_q, mw_q, halted_q;
`ifdef MYCPU_ILLEGAL_TRAP_EN
  logic        illegal_q;
`endif

  logic [15:0] dec_ir_s, dec_const_s, dec_off_s;
  logic [3:0]  dec_fs_s;
  logic [2:0]  dec_da_s, dec_aa_s, dec_ba_s, dec_dr_s;
  logic [1:0]  dec_cond_s;
  logic        dec_mb_s, dec_rw_s, dec_mw_s, dec_load_s, dec_branch_s, dec_halt_s, dec_illegal_s;
  logic        taken_s;

  // In DECODE the word is still on the memory bus, so the EXEC control word
  // is built from it directly and can be registered on that same edge.
  assign dec_ir_s = (state_q == ST_DECODE) ? imem_data_in : ir_q;

  mycpu_ctrl_decode u_decode (
    .ir_i        (dec_ir_s),
    .fs_o        (dec_fs_s),
    .da_o        (dec_da_s),
    .aa_o        (dec_aa_s),
    .ba_o        (dec_ba_s),
    .dr_o        (dec_dr_s),
    .const_o     (dec_const_s),
    .mb_o        (dec_mb_s),
    .rw_o        (dec_rw_s),
    .mw_o        (dec_mw_s),
    .is_load_o   (dec_load_s),
    .is_branch_o (dec_branch_s),
    .is_halt_o   (dec_halt_s),
    .illegal_o   (dec_illegal_s),
    .cond_o      (dec_cond_s),
    .off_o       (dec_off_s)
  );

  always_comb begin
    taken_s = 1'b0;
    case (br_cond_t'(dec_cond_s))
      BR_BRA:  taken_s = 1'b1;
      BR_BEQ:  taken_s = z_in;
      BR_BLT:  taken_s = n_in;
      BR_BNE:  taken_s = ~z_in;
      default: taken_s = 1'b0;
    endcase
  end

  // Every datapath output defaults to idle each cycle; only the EXEC and
  // LOAD_WB control words are loaded on the edge that enters those states.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_FETCH;
      pc_q     <= PC_RESET;
      ir_q     <= 16'h0000;
      fs_q     <= FMOVA;
      da_q     <= 3'd0;
      aa_q     <= 3'd0;
      ba_q     <= 3'd0;
      const_q  <= 16'h0000;
      mb_q     <= 1'b0;
      md_q     <= 1'b0;
      rw_q     <= 1'b0;
      mw_q     <= 1'b0;
      halted_q <= 1'b0;
`ifdef MYCPU_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      fs_q    <= FMOVA;
      da_q    <= 3'd0;
      aa_q    <= 3'd0;
      ba_q    <= 3'd0;
      const_q <= 16'h0000;
      mb_q    <= 1'b0;
      md_q    <= 1'b0;
      rw_q    <= 1'b0;
      mw_q    <= 1'b0;
      case (state_q)
        ST_FETCH: state_q <= ST_DECODE;
        ST_DECODE: begin
          ir_q    <= imem_data_in;
          pc_q    <= pc_q + 16'd1;
          fs_q    <= dec_fs_s;
          da_q    <= dec_da_s;
          aa_q    <= dec_aa_s;
          ba_q    <= dec_ba_s;
          const_q <= dec_const_s;
          mb_q    <= dec_mb_s;
          rw_q    <= dec_rw_s;
          mw_q    <= dec_mw_s;
          state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          if (dec_branch_s && taken_s) begin
            pc_q <= pc_q + dec_off_s;
          end
          if (dec_load_s) begin
            aa_q    <= dec_aa_s;
            da_q    <= dec_dr_s;
            md_q    <= 1'b1;
            rw_q    <= 1'b1;
            state_q <= ST_LOAD_WB;
          end else if (dec_halt_s) begin
            halted_q <= 1'b1;
            state_q  <= ST_HALT;
`ifdef MYCPU_ILLEGAL_TRAP_EN
          end else if (dec_illegal_s) begin
            halted_q  <= 1'b1;
            illegal_q <= 1'b1;
            state_q   <= ST_HALT;
`else
          end else if (dec_illegal_s) begin
            state_q <= ST_FETCH;
`endif
          end else begin
            state_q <= ST_FETCH;
          end
        end
        ST_LOAD_WB: state_q <= ST_FETCH;
        ST_HALT:    state_q <= ST_HALT;
        default:    state_q <= ST_FETCH;
      endcase
    end
  end

  assign imem_addr_out = pc_q;
  assign fs_out        = fs_q;
  assign da_out        = da_q;
  assign aa_out        = aa_q;
  assign ba_out        = ba_q;
  assign const_out     = const_q;
  assign mb_out        = mb_q;
  assign md_out        = md_q;
  assign rw_out        = rw_q;
  assign mw_out        = mw_q;
  assign halted_out    = halted_q;
`ifdef MYCPU_ILLEGAL_TRAP_EN
  assign illegal_out   = illegal_q;
`endif

endmodule
